// File: rtl/io_port_bank_if.sv
// Event-log port of io_port_bank: FWFT head with valid/ready plus occupancy and overflow status.
interface io_port_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                ev_valid;
    logic                ev_ready;
    logic [CH_W-1:0]     ev_ch;
    logic [WIDTH-1:0]    ev_data;
    logic [TS_WIDTH-1:0] ev_time;
    logic [CNT_W-1:0]    ev_count;
    logic                overflow;

    modport master (output ev_valid, ev_ch, ev_data, ev_time, ev_count, overflow, input ev_ready);
    modport slave  (input ev_valid, ev_ch, ev_data, ev_time, ev_count, overflow, output ev_ready);
endinterface

// File: rtl/io_port_bank.sv
// Multi-channel output latches and synchronised inputs; every output value change is
// logged with a cycle timestamp into a first-word-fall-through event FIFO.
module io_port_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [CH_W-1:0]           rd_ch,
    output logic [WIDTH-1:0]          rd_data,
    input  logic [CHANNELS*WIDTH-1:0] pin_in,
    output logic [CHANNELS*WIDTH-1:0] pin_out,
    io_port_bank_if.master            ev
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        logic [WIDTH-1:0]    data;
        logic [TS_WIDTH-1:0] ts;
    } ev_t;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    bank_t               pout_q, pout_d, sync1_q, sync2_q;
    logic [TS_WIDTH-1:0] ts_q;
    ev_t                 mem_q [DEPTH];
    ev_t                 head;
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                wr_ok, push_req, push, pop, full, empty;
    logic [WIDTH-1:0]    cur_val, rd_val;

    // Loop-based muxes keep out-of-range channel selects from indexing past the bank.
    always_comb begin
        cur_val = '0;
        rd_val  = '0;
        pout_d  = pout_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_ch == CH_W'(k)) cur_val = pout_q[k];
            if (rd_ch == CH_W'(k)) rd_val  = sync2_q[k];
            if (wr_ok && wr_ch == CH_W'(k)) pout_d[k] = wr_data;
        end
    end

    assign wr_ok    = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(CHANNELS));
    assign push_req = wr_ok && (cur_val != wr_data);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign pop      = !empty && ev.ev_ready;
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign push     = push_req && (!full || pop);
    assign ovf_d    = ovf_q | (push_req & ~push);
    assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ts_q    <= '0;
            pout_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_q + TS_WIDTH'(1);
            pout_q  <= pout_d;
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) mem_q[wptr_q] <= '{ch: wr_ch, data: wr_data, ts: ts_q};
    end

    assign head        = empty ? '0 : mem_q[rptr_q];
    assign ev.ev_valid = !empty;
    assign ev.ev_ch    = head.ch;
    assign ev.ev_data  = head.data;
    assign ev.ev_time  = head.ts;
    assign ev.ev_count = cnt_q;
    assign ev.overflow = ovf_q;
    assign pin_out     = pout_q;
    assign rd_data     = rd_val;
endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: model queue of expected events, checked at the FIFO head.
module tb_io_port_bank;
    localparam int W   = 4;
    localparam int CH  = 3;
    localparam int D   = 8;
    localparam int TSW = 16;
    localparam int CHW = 2;
    localparam int EVW = CHW + W + TSW;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [CHW-1:0]    wr_ch = '0;
    logic [W-1:0]      wr_data = '0;
    logic [CHW-1:0]    rd_ch = '0;
    logic [W-1:0]      rd_data;
    logic [CH*W-1:0]   pin_in = '0;
    logic [CH*W-1:0]   pin_out;
    logic [TSW-1:0]    tb_ts;

    logic [EVW-1:0]    sb[$];
    logic [CH*W-1:0]   exp_pin;
    logic              exp_ovf;
    int                n_chk = 0;
    int                n_err = 0;

    io_port_bank_if #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_WIDTH(TSW)) ev_if ();

    io_port_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_WIDTH(TSW)) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .rd_ch   (rd_ch),
        .rd_data (rd_data),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .ev      (ev_if)
    );

    always #5 clock = ~clock;

    // Independent cycle stamp: value held before an edge is what that edge logs.
    always @(posedge clock) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        ev_if.ev_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        exp_pin = '0;
        exp_ovf = 1'b0;
        chk("rst_pin", pin_out, 0);
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_count", ev_if.ev_count, 0);
        chk("rst_ovf", ev_if.overflow, 0);
        chk("rst_rd", rd_data, 0);
    endtask

    // One cycle: check head, drive write/ready, update the model, then check state after the edge.
    task automatic step(input bit wen, input int ch, input logic [W-1:0] d, input bit rdy);
        if (sb.size() > 0) chk("head", {ev_if.ev_ch, ev_if.ev_data, ev_if.ev_time}, sb[0]);
        else               chk("empty_head", {ev_if.ev_ch, ev_if.ev_data, ev_if.ev_time}, 0);
        wr_en = wen;
        wr_ch = CHW'(ch);
        wr_data = d;
        ev_if.ev_ready = rdy;
        if (rdy && sb.size() > 0) void'(sb.pop_front());
        if (wen && ch < CH && d != exp_pin[ch*W +: W]) begin
            if (sb.size() < D) sb.push_back({CHW'(ch), d, tb_ts});
            else               exp_ovf = 1'b1;
        end
        if (wen && ch < CH) exp_pin[ch*W +: W] = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        ev_if.ev_ready = 1'b0;
        chk("count", ev_if.ev_count, sb.size());
        chk("valid", ev_if.ev_valid, sb.size() > 0);
        chk("pin_out", pin_out, exp_pin);
        chk("ovf", ev_if.overflow, exp_ovf);
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        exp_pin = '0;
        exp_ovf = 1'b0;
        do_reset();

        // Single event stamped at cycle 5, then a same-value rewrite.
        while (tb_ts != 5) step(0, 0, '0, 0);
        step(1, 1, 4'hA, 0);
        chk("t2_pin1", pin_out[7:4], 4'hA);
        chk("t2_ch", ev_if.ev_ch, 1);
        chk("t2_data", ev_if.ev_data, 4'hA);
        chk("t2_time", ev_if.ev_time, 5);
        step(1, 1, 4'hA, 0);
        chk("t2_rewrite", ev_if.ev_count, 1);

        // Overflow: DEPTH+1 changes with no consumer, then drain in order.
        do_reset();
        for (int i = 1; i <= D + 1; i++) step(1, 0, W'(i), 0);
        chk("t3_count", ev_if.ev_count, D);
        chk("t3_ovf", ev_if.overflow, 1);
        chk("t3_head", ev_if.ev_data, 1);
        repeat (D) step(0, 0, '0, 1);
        chk("t3_empty", ev_if.ev_valid, 0);
        chk("t3_ovf_sticky", ev_if.overflow, 1);

        // Full FIFO with simultaneous pop and push.
        do_reset();
        for (int i = 1; i <= D; i++) step(1, 2, W'(i), 0);
        step(1, 2, 4'hC, 1);
        chk("t4_count", ev_if.ev_count, D);
        chk("t4_ovf", ev_if.overflow, 0);
        repeat (D - 1) step(0, 0, '0, 1);
        chk("t4_last", ev_if.ev_data, 4'hC);
        step(0, 0, '0, 1);

        // Input synchroniser latency and out-of-range channels.
        do_reset();
        rd_ch = '0;
        pin_in[3:0] = 4'h3;
        step(0, 0, '0, 0);
        chk("t5_sync_1edge", rd_data, 0);
        step(0, 0, '0, 0);
        chk("t5_sync_2edge", rd_data, 4'h3);
        rd_ch = CHW'(CH);
        #1;
        chk("t5_rd_oob", rd_data, 0);
        rd_ch = '0;
        step(1, CH, 4'hF, 0);
        chk("t5_wr_oob_cnt", ev_if.ev_count, 0);

        // Reset with pending events; timestamp restarts.
        step(1, 0, 4'h1, 0);
        step(1, 1, 4'h2, 0);
        step(1, 2, 4'h3, 0);
        chk("t6_pending", ev_if.ev_count, 3);
        do_reset();
        step(1, 0, 4'h5, 0);
        chk("t6_ts", ev_if.ev_time, 0);
        step(0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
